ip_codma_bus_responder: RTL and testbench
=========================================

// Module: ip_codma_bus_responder
// PURPOSE
// - Slave/responder end of the CODMA BUS_IF. It serves the address and data phases issued by the CODMA master.
// - Holds a 64-bit-wide local memory. It answers reads with back-to-back read_valid beats and accepts write beats.
// - It signals error for illegal requests.
// - Used as the on-chip scratch target and as the bench memory for the DMA data-phase logic.
// PARAMETERS
// - BASE_ADDR   32'h0000_1000  byte address of word 0
// - DEPTH       64             number of 64-bit words (power of 2, >= 8)
// - RD_LATENCY  2              cycles from grant to first read_valid beat (>= 1)
// PORTS
// - clk_i         in   1   clock
// - reset_n_i     in   1   asynchronous, active-low reset
// - bus_valid     in   1   master address-phase request
// - bus_addr      in   32  byte address, 8-byte aligned
// - bus_write     in   1   1 = write, 0 = read
// - bus_size      in   4   transfer size code: 3 = 1 beat, 8 = 2 beats, 9 = 4 beats
// - bus_grant     out  1   address phase accepted (1-cycle pulse)
// - read_valid    out  1   read_data holds a valid beat
// - read_data     out  64  read beat; [31:0] = lower word, [63:32] = upper word
// - write_valid   in   1   master presents a write beat
// - write_data    in   64  write beat
// - write_ready   out  1   write beat consumed this cycle (valid & ready)
// - error         out  1   1-cycle pulse, request rejected
// - busy_o        out  1   state != RS_IDLE
// BEHAVIOUR
// - Reset: state = RS_IDLE. bus_grant, read_valid, write_ready, error and busy_o = 0. read_data = 0.
// - Memory contents are not reset.
// - RS_IDLE, on bus_valid: decode bus_size to beats_r; latch addr, word index = (addr-BASE_ADDR)>>3.
//   - Illegal request when any of: size not in {3,8,9}; addr[2:0] != 0; addr < BASE_ADDR;
//     last beat index >= DEPTH (the burst must not wrap).
//   - Illegal -> RS_ERROR. error = 1 next cycle, no grant.
//   - Legal -> bus_grant = 1 next cycle; go to RS_RD_WAIT or RS_WR_DATA.
// - bus_valid while not RS_IDLE is ignored. No grant is issued until the block returns to idle.
//   The master holds bus_valid.
// - RS_RD_WAIT: counts RD_LATENCY-1 cycles, then goes to RS_RD_DATA.
// - RS_RD_DATA:
//   - read_valid = 1 for exactly beats_r consecutive cycles.
//   - read_data = mem[idx + beat].
//   - After the last beat, read_valid drops and the block returns to RS_IDLE.
//   - The master sees read_valid low on the cycle after the last beat.
// - RS_WR_DATA:
//   - write_ready = write_valid (combinational).
//   - Each handshake writes mem[idx + beat] and increments beat.
//   - The last handshake returns the block to RS_IDLE.
//   - write_valid with write_ready low is not consumed.
// - RS_ERROR: error = 1 for one cycle, then RS_IDLE.
//   No read_valid or write_ready is asserted for a rejected request.
// - Latency: a legal read gives first beat RD_LATENCY+1 cycles after the bus_valid sample. Single-cycle writes.
// - Beat counter is 3 bits and compares against beats_r. Index arithmetic is unsigned $clog2(DEPTH) bits.
//   Range is checked before the burst starts, so no wrap occurs.
// - Async reset mid-burst: outputs drop immediately.
//   A partially written burst leaves the already written beats in memory.
// CONFIGURATION
// - CODMA_RESP_STALL_EN defined:
//   - RS_RD_DATA inserts one idle cycle (read_valid = 0) between consecutive beats.
//   - RS_WR_DATA holds write_ready low on every second cycle.
//   - Models a slow target.
// - Undefined: fully back-to-back as described above.
// STRUCTURE
// - Add to ip_codma_machine_states_pkg:
//   - resp_state_t {RS_IDLE, RS_RD_WAIT, RS_RD_DATA, RS_WR_DATA, RS_ERROR}
//   - size-code constants SZ_1BEAT = 3, SZ_2BEAT = 8, SZ_4BEAT = 9
//   - function size_to_beats()
// - Sub-module ip_codma_resp_mem: 1 write port plus 1 read port, synchronous-read DEPTH x 64 array.
//   Read address is issued one cycle ahead of the beat.
// TESTING
// - Preload mem[0..3] = 64'hA0..A3. Read addr 0x1000, size 9:
//   grant; after RD_LATENCY, 4 contiguous read_valid beats A0, A1, A2, A3; then idle.
// - Write addr 0x1008, size 8, beats 64'h11, 64'h22: two write_ready handshakes;
//   then read back size 8 returns 11, 22.
// - Read addr 0x1004 (unaligned) -> error 1-cycle pulse, no grant, no read_valid.
//   Size 5 -> error.
// - Read addr BASE+(DEPTH-2)*8, size 9 -> error (overrun).
//   Same address, size 8 -> 2 beats, OK.
// - Drop reset_n_i during beat 2 of a size-9 read: read_valid = 0 immediately;
//   after reset release the block accepts a new size-3 read.
// - With CODMA_RESP_STALL_EN: a size-9 read shows read_valid pattern 1010101 over 7 cycles.

Source files
------------

// File: rtl/ip_codma_machine_states_pkg.sv
// Shared CODMA state and size-code definitions.
// Holds the bus responder state type and the bus_size decoding.
package ip_codma_machine_states_pkg;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_RD_WAIT,
        RS_RD_DATA,
        RS_WR_DATA,
        RS_ERROR
    } resp_state_t;

    localparam logic [3:0] SZ_1BEAT = 4'd3;
    localparam logic [3:0] SZ_2BEAT = 4'd8;
    localparam logic [3:0] SZ_4BEAT = 4'd9;

    // Returns 0 for an unsupported size code.
    function automatic logic [2:0] size_to_beats(input logic [3:0] size);
        case (size)
            SZ_1BEAT: return 3'd1;
            SZ_2BEAT: return 3'd2;
            SZ_4BEAT: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ip_codma_bus_responder_if.sv
// CODMA bus: address phase, read data phase and write data phase signals.
// The master drives requests and write beats, the slave answers.
interface ip_codma_bus_responder_if;

    logic        bus_valid;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic [3:0]  bus_size;
    logic        bus_grant;
    logic        read_valid;
    logic [63:0] read_data;
    logic        write_valid;
    logic [63:0] write_data;
    logic        write_ready;
    logic        error;

    modport master (
        output bus_valid, bus_addr, bus_write, bus_size, write_valid, write_data,
        input  bus_grant, read_valid, read_data, write_ready, error
    );

    modport slave (
        input  bus_valid, bus_addr, bus_write, bus_size, write_valid, write_data,
        output bus_grant, read_valid, read_data, write_ready, error
    );

endinterface

// File: rtl/ip_codma_resp_mem.sv
// DEPTH x 64-bit scratch array, one write port and one synchronous read port.
// The read register is cleared by reset; the array itself is not.
module ip_codma_resp_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ip_codma_bus_responder.sv
// CODMA bus responder: slave end of the CODMA bus backed by a DEPTH x 64-bit scratch memory.
// Define CODMA_RESP_STALL_EN to model a slow target (gaps between read beats, write_ready every other cycle).
module ip_codma_bus_responder
    import ip_codma_machine_states_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          DEPTH      = 64,
    parameter int          RD_LATENCY = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    ip_codma_bus_responder_if.slave  bus,
    output logic                     busy_o
);

    // state      | meaning
    // RS_IDLE    | waiting for bus_valid, decodes and range-checks the request
    // RS_RD_WAIT | read granted, burning the remaining read latency
    // RS_RD_DATA | issuing memory reads, one read_valid beat per issue
    // RS_WR_DATA | accepting write beats until the burst is complete
    // RS_ERROR   | request rejected, error pulse is on the bus

    localparam int AW        = $clog2(DEPTH);
    localparam int WW        = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
    localparam int WAIT_LOAD = (RD_LATENCY > 2) ? RD_LATENCY - 2 : 0;
`ifdef CODMA_RESP_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    resp_state_t   state;
    logic [2:0]    beats_r;
    logic [2:0]    beat;
    logic [AW-1:0] idx_r;
    logic [WW-1:0] wait_cnt;
    logic          gap;
    logic          grant_r;
    logic          read_valid_r;
    logic          error_r;

    logic [2:0]    req_beats;
    logic [31:0]   req_off;
    logic          req_legal;
    logic          rd_issue;
    logic          wr_hs;
    logic [AW-1:0] beat_addr;
    logic [63:0]   mem_rd_data;

    // The whole burst must fit below DEPTH so the index never wraps.
    always_comb begin
        req_beats = size_to_beats(bus.bus_size);
        req_off   = (bus.bus_addr - BASE_ADDR) >> 3;
        req_legal = (req_beats != 3'd0)
                 && (bus.bus_addr[2:0] == 3'b000)
                 && (bus.bus_addr >= BASE_ADDR)
                 && ((req_off + 32'(req_beats) - 32'd1) < 32'(DEPTH));
    end

    assign beat_addr = idx_r + AW'(beat);
    assign rd_issue  = (state == RS_RD_DATA) && (beat != beats_r) && !(STALL_EN && gap);
    assign wr_hs     = (state == RS_WR_DATA) && bus.write_valid && !(STALL_EN && gap);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= RS_IDLE;
            beats_r      <= '0;
            beat         <= '0;
            idx_r        <= '0;
            wait_cnt     <= '0;
            gap          <= 1'b0;
            grant_r      <= 1'b0;
            read_valid_r <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            grant_r      <= 1'b0;
            error_r      <= 1'b0;
            read_valid_r <= 1'b0;
            case (state)
                RS_IDLE: begin
                    beat <= '0;
                    gap  <= 1'b0;
                    if (bus.bus_valid) begin
                        beats_r  <= req_beats;
                        idx_r    <= req_off[AW-1:0];
                        wait_cnt <= WW'(WAIT_LOAD);
                        if (!req_legal) begin
                            state   <= RS_ERROR;
                            error_r <= 1'b1;
                        end else begin
                            grant_r <= 1'b1;
                            if (bus.bus_write) begin
                                state <= RS_WR_DATA;
                            end else if (RD_LATENCY == 1) begin
                                state <= RS_RD_DATA;
                            end else begin
                                state <= RS_RD_WAIT;
                            end
                        end
                    end
                end
                RS_RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= RS_RD_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end
                end
                RS_RD_DATA: begin
                    // The beat issued here is presented by the memory read register next cycle.
                    if (beat == beats_r) begin
                        state <= RS_IDLE;
                    end else if (STALL_EN && gap) begin
                        gap <= 1'b0;
                    end else begin
                        read_valid_r <= 1'b1;
                        beat         <= beat + 3'd1;
                        gap          <= 1'b1;
                    end
                end
                RS_WR_DATA: begin
                    gap <= ~gap;
                    if (wr_hs) begin
                        beat <= beat + 3'd1;
                        if ((beat + 3'd1) == beats_r) begin
                            state <= RS_IDLE;
                        end
                    end
                end
                RS_ERROR: begin
                    state <= RS_IDLE;
                end
                default: begin
                    state <= RS_IDLE;
                end
            endcase
        end
    end

    ip_codma_resp_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .wr_en     (wr_hs),
        .wr_addr   (beat_addr),
        .wr_data   (bus.write_data),
        .rd_en     (rd_issue),
        .rd_addr   (beat_addr),
        .rd_data   (mem_rd_data)
    );

    assign bus.bus_grant   = grant_r;
    assign bus.read_valid  = read_valid_r;
    assign bus.read_data   = mem_rd_data;
    assign bus.write_ready = wr_hs;
    assign bus.error       = error_r;
    assign busy_o          = (state != RS_IDLE);

endmodule

// File: tb/tb_ip_codma_bus_responder.sv
// Self-checking bench for ip_codma_bus_responder: directed scenarios plus randomized
// transactions checked against a word-array model of the scratch memory.
module tb_ip_codma_bus_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;
    localparam int          RDL   = 2;
`ifdef CODMA_RESP_STALL_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b0;
    logic busy_o;

    ip_codma_bus_responder_if bus_if ();

    ip_codma_bus_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RDL)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus_if.slave),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] mdl [DEPTH];
    logic [63:0] wbuf [4];
    logic [15:0] gnt_tr, err_tr, rv_tr, wr_tr;
    logic [63:0] rdq [$];
    int          hs_cnt;

    function automatic int beats_of(input logic [3:0] size);
        return (size == 4'd3) ? 1 : (size == 4'd8) ? 2 : (size == 4'd9) ? 4 : 0;
    endfunction

    function automatic bit legal(input logic [31:0] addr, input logic [3:0] size);
        longint off;
        if (beats_of(size) == 0 || (addr % 8) != 0 || addr < BASE) return 1'b0;
        off = (longint'(addr) - longint'(BASE)) / 8;
        return (off + beats_of(size)) <= DEPTH;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr - BASE) / 8);
    endfunction

    // Cycle 0 of a trace is the cycle right after the request was sampled.
    function automatic logic [15:0] exp_tr(input int first, input int beats);
        logic [15:0] v;
        v = '0;
        for (int b = 0; b < beats; b++) v[first + b*STRIDE] = 1'b1;
        return v;
    endfunction

    task automatic idle_bus();
        bus_if.bus_valid   = 1'b0;
        bus_if.bus_addr    = '0;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_size    = '0;
        bus_if.write_valid = 1'b0;
        bus_if.write_data  = '0;
    endtask

    // Issues one request, drives write beats from wbuf, records 16 cycles of bus activity.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [3:0] size);
        int nwr;
        nwr = (beats_of(size) == 0) ? 1 : beats_of(size);
        gnt_tr = '0; err_tr = '0; rv_tr = '0; wr_tr = '0;
        rdq.delete();
        hs_cnt = 0;
        @(posedge clk_i); #1;
        bus_if.bus_valid = 1'b1;
        bus_if.bus_addr  = addr;
        bus_if.bus_write = wr;
        bus_if.bus_size  = size;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_i); #1;
            if (i == 1) bus_if.bus_valid = 1'b0;
            bus_if.write_valid = wr && (hs_cnt < nwr);
            bus_if.write_data  = (hs_cnt < 4) ? wbuf[hs_cnt] : 64'd0;
            @(negedge clk_i);
            gnt_tr[i] = bus_if.bus_grant;
            err_tr[i] = bus_if.error;
            rv_tr[i]  = bus_if.read_valid;
            wr_tr[i]  = bus_if.write_ready;
            if (bus_if.read_valid) rdq.push_back(bus_if.read_data);
            if (bus_if.write_valid && bus_if.write_ready) hs_cnt++;
        end
        idle_bus();
    endtask

    task automatic test_reset();
        idle_bus();
        reset_n_i = 1'b0;
        #12;
        n_vec++;
        if ({bus_if.bus_grant, bus_if.read_valid, bus_if.write_ready, bus_if.error, busy_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 00000", {bus_if.bus_grant, bus_if.read_valid, bus_if.write_ready, bus_if.error, busy_o});
        end
        n_vec++;
        if (bus_if.read_data !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_read_data: got %h expected 0", bus_if.read_data);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    task automatic test_preload();
        for (int blk = 0; blk < DEPTH/4; blk++) begin
            for (int b = 0; b < 4; b++) wbuf[b] = {$urandom, $urandom};
            run_txn(BASE + 32'(blk*32), 1'b1, 4'd9);
            for (int b = 0; b < 4; b++) mdl[blk*4 + b] = wbuf[b];
            n_vec++;
            if (hs_cnt !== 4 || gnt_tr !== 16'h0001 || err_tr !== 16'h0000) begin
                n_bad++;
                $display("FAIL preload_blk%0d: got hs=%0d gnt=%h err=%h expected hs=4 gnt=0001 err=0000", blk, hs_cnt, gnt_tr, err_tr);
            end
        end
    endtask

    task automatic test_read_burst();
        for (int b = 0; b < 4; b++) wbuf[b] = 64'hA0 + 64'(b);
        run_txn(BASE, 1'b1, 4'd9);
        for (int b = 0; b < 4; b++) mdl[b] = wbuf[b];
        n_vec++;
        if (wr_tr !== exp_tr(0, 4)) begin
            n_bad++;
            $display("FAIL a0_write_ready: got %h expected %h", wr_tr, exp_tr(0, 4));
        end
        run_txn(BASE, 1'b0, 4'd9);
        n_vec++;
        if (gnt_tr !== 16'h0001 || err_tr !== 16'h0000) begin
            n_bad++;
            $display("FAIL a0_read_grant: got gnt=%h err=%h expected gnt=0001 err=0000", gnt_tr, err_tr);
        end
        n_vec++;
        if (rv_tr !== exp_tr(RDL, 4)) begin
            n_bad++;
            $display("FAIL a0_read_valid: got %h expected %h", rv_tr, exp_tr(RDL, 4));
        end
        n_vec++;
        if (rdq.size() != 4 || rdq[0] !== 64'hA0 || rdq[1] !== 64'hA1 || rdq[2] !== 64'hA2 || rdq[3] !== 64'hA3) begin
            n_bad++;
            $display("FAIL a0_read_data: got %0d beats first %h expected A0 A1 A2 A3", rdq.size(), (rdq.size() > 0) ? rdq[0] : 64'hx);
        end
    endtask

    task automatic test_write_readback();
        wbuf[0] = 64'h11; wbuf[1] = 64'h22;
        run_txn(BASE + 32'h8, 1'b1, 4'd8);
        mdl[1] = 64'h11; mdl[2] = 64'h22;
        n_vec++;
        if (hs_cnt !== 2 || wr_tr !== exp_tr(0, 2)) begin
            n_bad++;
            $display("FAIL wr2_handshakes: got hs=%0d ready=%h expected hs=2 ready=%h", hs_cnt, wr_tr, exp_tr(0, 2));
        end
        run_txn(BASE + 32'h8, 1'b0, 4'd8);
        n_vec++;
        if (rdq.size() != 2 || rdq[0] !== 64'h11 || rdq[1] !== 64'h22 || rv_tr !== exp_tr(RDL, 2)) begin
            n_bad++;
            $display("FAIL wr2_readback: got %0d beats rv=%h expected 11 22 rv=%h", rdq.size(), rv_tr, exp_tr(RDL, 2));
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3] = '{BASE + 32'h4, BASE, BASE - 32'h8};
        logic [3:0]  sizes [3] = '{4'd9, 4'd5, 4'd3};
        for (int k = 0; k < 3; k++) begin
            run_txn(addrs[k], k == 2, sizes[k]);
            n_vec++;
            if (err_tr !== 16'h0001 || gnt_tr !== 16'h0000 || rv_tr !== 16'h0000 || wr_tr !== 16'h0000) begin
                n_bad++;
                $display("FAIL err_case%0d: got err=%h gnt=%h rv=%h wr=%h expected err=0001 others 0", k, err_tr, gnt_tr, rv_tr, wr_tr);
            end
        end
    endtask

    task automatic test_overrun();
        run_txn(BASE + 32'((DEPTH-2)*8), 1'b0, 4'd9);
        n_vec++;
        if (err_tr !== 16'h0001 || gnt_tr !== 16'h0000 || rv_tr !== 16'h0000) begin
            n_bad++;
            $display("FAIL overrun_4beat: got err=%h gnt=%h rv=%h expected err=0001", err_tr, gnt_tr, rv_tr);
        end
        run_txn(BASE + 32'((DEPTH-2)*8), 1'b0, 4'd8);
        n_vec++;
        if (rv_tr !== exp_tr(RDL, 2) || rdq.size() != 2 || rdq[0] !== mdl[DEPTH-2] || rdq[1] !== mdl[DEPTH-1]) begin
            n_bad++;
            $display("FAIL top_2beat: got rv=%h beats=%0d expected rv=%h data %h %h", rv_tr, rdq.size(), exp_tr(RDL, 2), mdl[DEPTH-2], mdl[DEPTH-1]);
        end
        run_txn(BASE + 32'((DEPTH-1)*8), 1'b0, 4'd8);
        n_vec++;
        if (err_tr !== 16'h0001 || rv_tr !== 16'h0000) begin
            n_bad++;
            $display("FAIL overrun_last_2beat: got err=%h rv=%h expected err=0001 rv=0000", err_tr, rv_tr);
        end
    endtask

    task automatic test_random();
        logic [3:0]  size_pick [7] = '{4'd3, 4'd8, 4'd9, 4'd3, 4'd8, 4'd9, 4'd0};
        logic [31:0] addr;
        logic [3:0]  size;
        logic        wr;
        int          w, nb;
        for (int t = 0; t < 60; t++) begin
            size = size_pick[$urandom_range(0, 6)];
            if (size == 4'd0) size = 4'($urandom);
            addr = BASE + 32'($urandom_range(0, DEPTH-1) * 8);
            case ($urandom_range(0, 9))
                0: addr = addr + 32'($urandom_range(1, 7));
                1: addr = BASE - 32'($urandom_range(1, 64) * 8);
                default: ;
            endcase
            wr = 1'($urandom);
            for (int b = 0; b < 4; b++) wbuf[b] = {$urandom, $urandom};
            run_txn(addr, wr, size);
            nb = beats_of(size);
            n_vec++;
            if (!legal(addr, size)) begin
                if (err_tr !== 16'h0001 || gnt_tr !== 16'h0000 || rv_tr !== 16'h0000 || wr_tr !== 16'h0000) begin
                    n_bad++;
                    $display("FAIL rnd%0d_reject a=%h s=%0d: got err=%h gnt=%h rv=%h wr=%h expected err=0001", t, addr, size, err_tr, gnt_tr, rv_tr, wr_tr);
                end
            end else if (wr) begin
                w = word_of(addr);
                for (int b = 0; b < nb; b++) mdl[w + b] = wbuf[b];
                if (gnt_tr !== 16'h0001 || err_tr !== 16'h0000 || wr_tr !== exp_tr(0, nb) || hs_cnt != nb) begin
                    n_bad++;
                    $display("FAIL rnd%0d_write a=%h s=%0d: got gnt=%h ready=%h hs=%0d expected gnt=0001 ready=%h hs=%0d", t, addr, size, gnt_tr, wr_tr, hs_cnt, exp_tr(0, nb), nb);
                end
            end else begin
                w = word_of(addr);
                if (gnt_tr !== 16'h0001 || err_tr !== 16'h0000 || rv_tr !== exp_tr(RDL, nb) || rdq.size() != nb) begin
                    n_bad++;
                    $display("FAIL rnd%0d_read a=%h s=%0d: got gnt=%h rv=%h beats=%0d expected rv=%h", t, addr, size, gnt_tr, rv_tr, rdq.size(), exp_tr(RDL, nb));
                end else begin
                    for (int b = 0; b < nb; b++) begin
                        n_vec++;
                        if (rdq[b] !== mdl[w + b]) begin
                            n_bad++;
                            $display("FAIL rnd%0d_data beat%0d: got %h expected %h", t, b, rdq[b], mdl[w + b]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        bit hit;
        seen = 0;
        hit  = 1'b0;
        @(posedge clk_i); #1;
        bus_if.bus_valid = 1'b1;
        bus_if.bus_addr  = BASE;
        bus_if.bus_write = 1'b0;
        bus_if.bus_size  = 4'd9;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk_i);
            if (bus_if.bus_grant) bus_if.bus_valid = 1'b0;
            if (bus_if.read_valid) seen++;
            if (seen == 2) hit = 1'b1;
        end
        n_vec++;
        if (!hit) begin
            n_bad++;
            $display("FAIL midreset_beat2: got %0d beats expected 2 within 20 cycles", seen);
        end
        reset_n_i = 1'b0;
        idle_bus();
        #1;
        n_vec++;
        if ({bus_if.read_valid, busy_o} !== 2'b00 || bus_if.read_data !== 64'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got rv=%b busy=%b data=%h expected 0 0 0", bus_if.read_valid, busy_o, bus_if.read_data);
        end
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        run_txn(BASE + 32'h10, 1'b0, 4'd3);
        n_vec++;
        if (gnt_tr !== 16'h0001 || rv_tr !== exp_tr(RDL, 1) || rdq.size() != 1 || rdq[0] !== mdl[2]) begin
            n_bad++;
            $display("FAIL midreset_recover: got gnt=%h rv=%h beats=%0d expected gnt=0001 rv=%h data %h", gnt_tr, rv_tr, rdq.size(), exp_tr(RDL, 1), mdl[2]);
        end
    endtask

`ifdef CODMA_RESP_STALL_EN
    task automatic test_stall();
        run_txn(BASE, 1'b0, 4'd9);
        n_vec++;
        if (rv_tr[RDL +: 7] !== 7'b1010101) begin
            n_bad++;
            $display("FAIL stall_pattern: got %b expected 1010101", rv_tr[RDL +: 7]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_preload();
        test_read_burst();
        test_write_readback();
        test_errors();
        test_overrun();
        test_random();
        test_reset_mid_burst();
`ifdef CODMA_RESP_STALL_EN
        test_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
